lut_arbiter: RTL
================

Name: lut_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one registered activation LUT (21-bit in, 21-bit out, one-cycle latency, inputs en/bypass/shift_overf) between NREQ requesters.
- Each requester hands over one operand with a valid/ready handshake, including its bypass and shift-overflow flags.
- The block drives the LUT, captures its result and returns it to the granted requester with a valid/ready handshake.
- It sits between the per-lane accumulators and the single shared LUT instance.

Parameters:
- NREQ, 4, number of requesters (2..8); the grant index width is GW = clog2(NREQ).
- DW, 21, operand/result width; this must match the LUT.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- req_valid  input  NREQ  per-requester operand valid
- req_data  input  NREQ*DW  operands; requester i uses bits [i*DW +: DW]
- req_bypass  input  NREQ  per-requester bypass flag, sampled with the operand
- req_ovf  input  NREQ  per-requester shift-overflow flag, sampled with the operand
- req_ready  output  NREQ  one-hot acceptance pulse
- lut_in  output  DW  operand to LUT
- lut_bypass  output  1  to LUT bypass
- lut_shift_overf  output  1  to LUT shift_overf
- lut_en  output  1  LUT enable
- lut_out  input  DW  LUT registered result
- rsp_valid  output  NREQ  one-hot result valid
- rsp_data  output  DW  result (shared by all requesters)
- rsp_ready  input  NREQ  per-requester result accept
- grant_id  output  GW  index of the current/last grant
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset (reset=0, async) forces the following; all outputs are 0 in reset:
  - state=IDLE, rr_ptr=0
  - lut_in, lut_bypass, lut_shift_overf, lut_en all 0
  - rsp_data=0, rsp_valid=0, req_ready=0, grant_id=0, busy=0
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is set, compute g = the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, … modulo NREQ.
  - req_ready[g]=1 combinationally in this cycle only (Mealy); no other req_ready bit is high.
  - On the clock edge, register lut_in=req_data[g], lut_bypass=req_bypass[g], lut_shift_overf=req_ovf[g] and grant_id=g, then go to ISSUE.
  - With no valid, stay in IDLE.
- ISSUE:
  - lut_en=1 for exactly this cycle; the LUT samples on this edge.
  - Go to WAIT.
- WAIT:
  - lut_en=0; lut_out now holds the result.
  - Register rsp_data=lut_out and go to RESP.
- RESP:
  - rsp_valid[grant_id]=1, with rsp_data held stable.
  - When rsp_ready[grant_id]=1: clear rsp_valid, set rr_ptr=(grant_id+1) mod NREQ, go to IDLE.
  - rsp_ready bits of non-granted requesters are ignored.
- Timing:
  - Latency from the accept cycle to the first rsp_valid cycle is 3 clocks.
  - Minimum period is 4 clocks per operation when rsp_ready is held high.
- lut_in, lut_bypass and lut_shift_overf hold their last values outside ISSUE; lut_en is high only in ISSUE.
- No new request is accepted while busy=1; pending req_valid must be held by the requester (standard valid/ready).
- Fairness: the just-served requester has the lowest priority next time. With all NREQ requesters continuously valid, the grant order is 0, 1, …, NREQ-1, 0, …
- A requester that drops req_valid before being granted is simply not selected; no state is kept for it.
- The bypass/overflow flags are passed through unchanged; the LUT produces 0 for them, and this block does not special-case them.
- Reset mid-operation (any state) aborts the transaction silently: no rsp_valid is emitted, rr_ptr returns to 0, and the LUT is reset by the same reset.
- rsp_ready is stalled indefinitely: the block stays in RESP and all other requesters wait.

Test Plan:
- Single request:
  - Stimulus: after reset, req_valid[0]=1, req_data[0]=0x000000, flags 0.
  - Required: req_ready[0] pulses 1 cycle; lut_en is high exactly 1 cycle, 1 clock later; rsp_valid[0] rises 3 clocks after accept with rsp_data=0x005851.
- Negative-range and top-bin values:
  - Stimulus: requester 2 sends 0x1D5A22, then 0x1FFB50.
  - Required: rsp_data=0x000000, then 0x00170A; grant_id=2 for both.
- Bypass/overflow:
  - Stimulus: requester 1 sends 0x000100 with req_bypass=1, then again with req_ovf=1.
  - Required: lut_bypass (respectively lut_shift_overf)=1 during ISSUE; rsp_data=0 both times.
- Round robin:
  - Stimulus: all 4 req_valid held high with distinct data and rsp_ready tied high.
  - Required: grants 0, 1, 2, 3, 0; exactly one req_ready per 4-cycle window; no starvation over 32 operations.
- Backpressure:
  - Stimulus: rsp_ready[3]=0 for 10 cycles during a requester-3 response while requester 0 is valid.
  - Required: rsp_valid[3] and rsp_data stay stable and req_ready stays 0; requester 0 is granted in the IDLE cycle right after rsp_ready[3] goes high.
- Reset mid-transaction:
  - Stimulus: assert reset in WAIT.
  - Required: all outputs 0 immediately with no rsp_valid pulse; after release, the first grant starts the search from requester 0.

Source files
------------

// File: rtl/lut_arbiter_if.sv
// Requester-side and LUT-side signal bundle for lut_arbiter.
// The slave modport is the arbiter's view; master is the surrounding requesters/LUT.
interface lut_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 21
);
  localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_bypass;
  logic [NREQ-1:0]    req_ovf;
  logic [NREQ-1:0]    req_ready;

  logic [DW-1:0]      lut_in;
  logic               lut_bypass;
  logic               lut_shift_overf;
  logic               lut_en;
  logic [DW-1:0]      lut_out;

  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_data;
  logic [NREQ-1:0]    rsp_ready;

  logic [GW-1:0]      grant_id;
  logic               busy;

  modport master (
    output req_valid, req_data, req_bypass, req_ovf, rsp_ready, lut_out,
    input  req_ready, lut_in, lut_bypass, lut_shift_overf, lut_en,
           rsp_valid, rsp_data, grant_id, busy
  );

  modport slave (
    input  req_valid, req_data, req_bypass, req_ovf, rsp_ready, lut_out,
    output req_ready, lut_in, lut_bypass, lut_shift_overf, lut_en,
           rsp_valid, rsp_data, grant_id, busy
  );
endinterface

// File: rtl/lut_arbiter.sv
// Round-robin arbiter that time-shares one registered activation LUT between NREQ requesters.
// One operation at a time: IDLE (grant) -> ISSUE (lut_en) -> WAIT (capture) -> RESP (return).
module lut_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 21
) (
  input logic          clk,
  input logic          reset,
  lut_arbiter_if.slave bus
);
  localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [DW-1:0] lut_in_q, lut_in_d;
  logic          lut_byp_q, lut_byp_d;
  logic          lut_ovf_q, lut_ovf_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;

  logic [GW-1:0]   pick;
  logic            pick_vld;
  logic [NREQ-1:0] req_ready;
  logic [NREQ-1:0] rsp_valid;
  logic            lut_en;

  // First valid requester searching from rr_ptr upwards, wrapping modulo NREQ.
  always_comb begin
    int unsigned   idx;
    logic [GW-1:0] sel;
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    sel      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      sel = GW'(idx);
      if (!pick_vld && bus.req_valid[sel]) begin
        pick_vld = 1'b1;
        pick     = sel;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    lut_in_d   = lut_in_q;
    lut_byp_d  = lut_byp_q;
    lut_ovf_d  = lut_ovf_q;
    rsp_data_d = rsp_data_q;
    req_ready  = '0;
    rsp_valid  = '0;
    lut_en     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pick_vld) begin
          // Gated by reset so no acceptance pulse leaks out while held in reset.
          req_ready[pick] = reset;
          grant_d         = pick;
          lut_in_d        = bus.req_data[pick*DW +: DW];
          lut_byp_d       = bus.req_bypass[pick];
          lut_ovf_d       = bus.req_ovf[pick];
          state_d         = StIssue;
        end
      end
      StIssue: begin
        lut_en  = 1'b1;
        state_d = StWait;
      end
      StWait: begin
        rsp_data_d = bus.lut_out;
        state_d    = StResp;
      end
      StResp: begin
        rsp_valid[grant_q] = 1'b1;
        if (bus.rsp_ready[grant_q]) begin
          rr_ptr_d = (grant_q == GW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      lut_in_q   <= '0;
      lut_byp_q  <= 1'b0;
      lut_ovf_q  <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      lut_in_q   <= lut_in_d;
      lut_byp_q  <= lut_byp_d;
      lut_ovf_q  <= lut_ovf_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign bus.req_ready       = req_ready;
  assign bus.rsp_valid       = rsp_valid;
  assign bus.rsp_data        = rsp_data_q;
  assign bus.lut_in          = lut_in_q;
  assign bus.lut_bypass      = lut_byp_q;
  assign bus.lut_shift_overf = lut_ovf_q;
  assign bus.lut_en          = lut_en;
  assign bus.grant_id        = grant_q;
  assign bus.busy            = (state_q != StIdle);

endmodule
